// File: rtl/cfg_uart_tx.sv
// cfg_uart_tx: 8N1 UART transmitter for the configuration return path.
// Bytes are queued in a small FIFO and sent LSB-first. The tx line idles high.
// Optional feature macro CFG_UART_TX_PARITY_EN: when it is defined, an even-parity
// bit follows data bit 7, which gives 8E1 frames of 11 bits.
//
// state    | meaning
// ---------+-----------------------------------------------------
// S_IDLE   | line high; waiting for a byte in the FIFO
// S_START  | start bit (0)
// S_DATA   | data bits 0..7, r_shift[0] on the line
// S_PARITY | even parity of the byte (only with CFG_UART_TX_PARITY_EN)
// S_STOP   | stop bit (1); pops the next byte on its last cycle
module cfg_uart_tx #(
    parameter int CLK_DIV = 434,
    parameter int DEPTH   = 4
) (
    input  logic                     CLK,
    input  logic                     resetn,
    input  logic [7:0]               tx_data,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    output logic                     tx,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LOAD = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
`ifdef CFG_UART_TX_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_shift;
    logic [2:0]    r_idx;
    logic          r_tx;
`ifdef CFG_UART_TX_PARITY_EN
    logic          r_par;
`endif

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_bit_end;
    logic [7:0]    w_head;

    // Full when the pointers differ only in their wrap bit.
    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push    = tx_valid && !w_full;
    assign w_bit_end = (r_cnt == '0);
    assign w_pop     = !w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
    assign w_head    = r_mem[r_rptr[AW-1:0]];

    assign tx_ready   = !w_full;
    assign tx         = r_tx;
    assign busy       = (r_state != S_IDLE) || !w_empty;
    assign fifo_level = r_wptr - r_rptr;

    // FIFO storage; contents need no reset because the pointers gate every read.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= tx_data;
        end
    end

    // FIFO pointers, each wrapping modulo 2*DEPTH.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Serialiser FSM with a registered line output, which changes only on bit boundaries.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_idx   <= '0;
            r_tx    <= 1'b1;
`ifdef CFG_UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift <= w_head;
`ifdef CFG_UART_TX_PARITY_EN
                        r_par   <= ^w_head;
`endif
                        r_cnt   <= CNT_LOAD;
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_cnt   <= CNT_LOAD;
                        r_idx   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= CNT_LOAD;
                        if (r_idx == 3'd7) begin
`ifdef CFG_UART_TX_PARITY_EN
                            r_tx    <= r_par;
                            r_state <= S_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                            r_idx   <= r_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`ifdef CFG_UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_cnt   <= CNT_LOAD;
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (w_bit_end) begin
                        if (w_pop) begin
                            // Next byte starts right away, with no idle gap between frames.
                            r_shift <= w_head;
`ifdef CFG_UART_TX_PARITY_EN
                            r_par   <= ^w_head;
`endif
                            r_cnt   <= CNT_LOAD;
                            r_tx    <= 1'b0;
                            r_state <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_uart_tx.sv
// Testbench for cfg_uart_tx (CLK_DIV=4, DEPTH=4). A queue holds the bytes that were
// accepted. A line monitor decodes each frame from tx and checks it against the head
// of that queue.
module tb_cfg_uart_tx;

    localparam int DIV = 4;
`ifdef CFG_UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       CLK;
    logic       resetn;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_level;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_acc = 0;
    logic [7:0] exp_q [$];
    int         starts_q [$];

    logic [10:0] mon_bits;
    bit          mon_glitch;
    bit          mon_abort;

    cfg_uart_tx #(.CLK_DIV(DIV), .DEPTH(4)) dut (
        .CLK        (CLK),
        .resetn     (resetn),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout at cycle %0d", name, cyc);
    endtask

    task automatic check_frame(input logic [10:0] bits, input bit glitch);
        logic [7:0] e;
        logic [7:0] d;
        d = bits[8:1];
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame actual=%0h required=no_frame", d);
            return;
        end
        e = exp_q.pop_front();
        chk("frame_start", {31'd0, bits[0]}, 32'd0);
        chk("frame_data", {24'd0, d}, {24'd0, e});
`ifdef CFG_UART_TX_PARITY_EN
        chk("frame_parity", {31'd0, bits[9]}, {31'd0, ^e});
`endif
        chk("frame_stop", {31'd0, bits[FB-1]}, 32'd1);
        chk("frame_stable", {31'd0, glitch}, 32'd0);
    endtask

    // Line monitor: samples every cycle of a frame. The first sample of each bit sets
    // its value, and every later sample of that bit must match it.
    initial begin : monitor
        forever begin
            @(negedge CLK);
            if (resetn === 1'b1 && tx === 1'b0) begin
                starts_q.push_back(cyc);
                mon_bits   = '0;
                mon_glitch = 1'b0;
                mon_abort  = 1'b0;
                for (int c = 0; c < DIV * FB; c++) begin
                    if (c > 0) @(negedge CLK);
                    if (resetn !== 1'b1) begin
                        mon_abort = 1'b1;
                        break;
                    end
                    if (c % DIV == 0) mon_bits[c / DIV] = tx;
                    else if (tx !== mon_bits[c / DIV]) mon_glitch = 1'b1;
                end
                if (!mon_abort) check_frame(mon_bits, mon_glitch);
            end
        end
    end

    // Present a byte and hold it until it is accepted. Returns at the negedge that
    // follows the accepting edge, with tx_valid still high.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (!tx_ready) begin
            timeout("send_ready");
            tx_valid = 1'b0;
            return;
        end
        @(posedge CLK);
        exp_q.push_back(b);
        @(negedge CLK);
        last_acc = cyc;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        if (busy || exp_q.size() != 0) timeout("wait_idle");
        repeat (3) @(negedge CLK);
    endtask

    int t0;
    int t1;
    int sz0;
    int lows;
    logic [7:0] rb;

    initial begin
        resetn   = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        #12;
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_level", {29'd0, fifo_level}, 32'd0);
        @(negedge CLK);
        resetn = 1'b1;
        repeat (3) @(negedge CLK);
        chk("idle_tx", {31'd0, tx}, 32'd1);

        // Single byte: check latency and busy timing.
        send(8'hA5);
        tx_valid = 1'b0;
        chk("lat_tx_before", {31'd0, tx}, 32'd1);
        chk("lat_busy", {31'd0, busy}, 32'd1);
        chk("lat_level1", {29'd0, fifo_level}, 32'd1);
        @(negedge CLK);
        chk("lat_tx_fall", {31'd0, tx}, 32'd0);
        chk("lat_level0", {29'd0, fifo_level}, 32'd0);
        repeat (DIV * FB - 1) @(negedge CLK);
        chk("busy_last_stop", {31'd0, busy}, 32'd1);
        @(negedge CLK);
        chk("busy_clear", {31'd0, busy}, 32'd0);
        wait_idle();

        // Back-to-back bytes: the two frames must start exactly one frame apart.
        sz0 = starts_q.size();
        send(8'h00);
        send(8'hFF);
        tx_valid = 1'b0;
        wait_idle();
        chk("b2b_frames", starts_q.size(), sz0 + 2);
        if (starts_q.size() == sz0 + 2)
            chk("b2b_gap", starts_q[sz0 + 1] - starts_q[sz0], DIV * FB);

        // FIFO full: tx_ready is held low while four bytes wait.
        send(8'h01);
        t0 = last_acc;
        chk("full_lvl1", {29'd0, fifo_level}, 32'd1);
        send(8'h02);
        chk("pushpop_lvl1", {29'd0, fifo_level}, 32'd1);
        send(8'h03);
        send(8'h04);
        send(8'h05);
        chk("full_level", {29'd0, fifo_level}, 32'd4);
        chk("full_ready", {31'd0, tx_ready}, 32'd0);
        send(8'h06);
        tx_valid = 1'b0;
        chk("full_wait", last_acc - t0, DIV * FB + 2);
        wait_idle();

        // Push and pop in the same cycle with two bytes queued.
        send(8'h3C);
        t0 = last_acc;
        send(8'hC3);
        send(8'h5A);
        tx_valid = 1'b0;
        t1 = 0;
        while (cyc != t0 + DIV * FB && t1 < 200) begin
            @(negedge CLK);
            t1++;
        end
        chk("pp_level_before", {29'd0, fifo_level}, 32'd2);
        chk("pp_ready", {31'd0, tx_ready}, 32'd1);
        tx_data  = 8'h96;
        tx_valid = 1'b1;
        @(posedge CLK);
        exp_q.push_back(8'h96);
        @(negedge CLK);
        tx_valid = 1'b0;
        chk("pp_level_after", {29'd0, fifo_level}, 32'd2);
        chk("pp_next_start", {31'd0, tx}, 32'd0);
        wait_idle();

        // Parity check bytes: 0x07 has odd weight, 0x03 has even weight.
        send(8'h07);
        send(8'h03);
        tx_valid = 1'b0;
        wait_idle();

        // Reset asserted during data bit 3 of 0x55 while two bytes are queued.
        send(8'h55);
        send(8'h11);
        send(8'h22);
        tx_valid = 1'b0;
        repeat (16) @(negedge CLK);
        chk("mid_bit3", {31'd0, tx}, 32'd0);
        chk("mid_level", {29'd0, fifo_level}, 32'd2);
        resetn = 1'b0;
        #1;
        chk("mrst_tx", {31'd0, tx}, 32'd1);
        chk("mrst_level", {29'd0, fifo_level}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        repeat (3) @(negedge CLK);
        resetn = 1'b1;
        lows = 0;
        repeat (100) begin
            @(negedge CLK);
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        chk("post_rst_quiet", lows, 0);

        // Random bytes with random gaps between them.
        for (int i = 0; i < 24; i++) begin
            rb = 8'($urandom);
            send(rb);
            tx_valid = 1'b0;
            repeat ($urandom_range(0, 50)) @(negedge CLK);
        end
        wait_idle();
        chk("drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cfg_uart_tx.md
# cfg_uart_tx

Byte-oriented 8N1 UART transmitter, the return path of the fabric configuration UART. It buffers status and readback bytes from the configuration logic in a small FIFO and serialises them LSB-first onto a spare, otherwise unused GPIO pad, so the host can see configuration progress and the done state. It runs in the fabric clock domain, the same one as the configuration receiver.

## Interface

Parameters:
- `CLK_DIV`, default 434: clock cycles per bit. Legal range is 2 or more.
- `DEPTH`, default 4: FIFO entries. Must be a power of two, 2 or more.

Ports:
- `CLK` input, 1 bit: fabric/config clock. This is the only clock.
- `resetn` input, 1 bit: reset, asynchronous and active-low.
- `tx_data` input, 8 bits: byte to send.
- `tx_valid` input, 1 bit: `tx_data` is valid.
- `tx_ready` output, 1 bit: the FIFO can accept a byte (FIFO not full).
- `tx` output, 1 bit: serial line. Idle level is high.
- `busy` output, 1 bit: serialiser is not IDLE, or the FIFO is not empty.
- `fifo_level` output, $clog2(DEPTH)+1 bits: number of occupied FIFO entries.

## Operation

- **Reset values:**
  - `tx`=1, `tx_ready`=1, `busy`=0, `fifo_level`=0.
  - FIFO pointers are 0; the state is IDLE.
- **Push:**
  - A byte is accepted on a rising edge where `tx_valid` and `tx_ready` are both high.
  - `tx_ready` is derived from registered state only (low when `fifo_level`==DEPTH). A pop in the same cycle does not make room for a push in that cycle (no bypass).
  - A push attempted while full is not accepted, and the upstream holds the byte. The FIFO is never overwritten.
- **FIFO:**
  - Read and write pointers are $clog2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH.
  - Full and empty are decided from the pointer MSB comparison.
  - A simultaneous push and pop leaves `fifo_level` unchanged.
- **Serialiser FSM:** IDLE → START → DATA → [PARITY] → STOP.
  - IDLE: while the FIFO is not empty, pop the head byte into the shift register, load the bit counter with CLK_DIV-1, and set `tx`<=0. Next state is START.
  - START: drive 0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: drive `shift[0]` for CLK_DIV cycles per bit, then shift right. After bit index 7 completes, go to PARITY (if compiled in) or STOP.
  - PARITY: drive the even parity bit of the byte for CLK_DIV cycles, then go to STOP.
  - STOP: drive 1 for CLK_DIV cycles.
    - At the final cycle of STOP, if the FIFO is not empty, pop and enter START directly. There is no idle gap.
    - Otherwise go to IDLE.
- **Timing counter:** counts down from CLK_DIV-1 to 0. It is reloaded at every bit boundary and is $clog2(CLK_DIV) bits wide.
- **Output register:** `tx` is a register. It never glitches and changes only on bit boundaries.
- **Reset during a frame:** asserting `resetn` low forces `tx` high immediately (asynchronously) and discards the FIFO contents and the partial frame. After release, the block resumes idle.

## Timing

- **Latency:**
  - A byte is pushed at edge N into an empty FIFO with the serialiser idle.
  - `tx` falls at edge N+1.
  - The start bit occupies cycles N+1 to N+CLK_DIV.
- **Frame length:** 10·CLK_DIV cycles, or 11·CLK_DIV with parity.
- **Back-to-back bytes:** the next start bit begins exactly one bit time after the previous stop bit began.
- **`busy`:**
  - `busy` goes high the cycle after the accepting edge.
  - `busy` goes low the cycle after the last stop-bit cycle, provided the FIFO is empty.
- **`fifo_level`:** updates one edge after each push or pop.

## Configuration

- Macro: `CFG_UART_TX_PARITY_EN`.
- **Defined:** an even-parity bit is inserted between data bit 7 and the stop bit, giving 8E1 frames of 11 bits.
- **Undefined:** the PARITY state and its logic are absent, giving 8N1 frames of 10 bits.

## Test plan

- **Single byte:** reset, CLK_DIV=4, push 0xA5 → `tx` bit sequence is 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. `tx` falls 1 cycle after the push. `busy` clears 40 cycles after `tx` falls.
- **Back-to-back:** push 0x00 then 0xFF on consecutive cycles → 20 bit times with no idle gap. Bits 2–9 of the second frame are all 1.
- **FIFO full:** hold `tx_valid` high with bytes 0x01..0x06, DEPTH=4. Check:
  - `tx_ready` drops while `fifo_level`=4.
  - All six bytes are transmitted in order, none lost or duplicated.
- **Reset mid-frame:** assert `resetn` low during data bit 3 of 0x55 with two bytes queued. Check:
  - `tx`=1 immediately.
  - `fifo_level`=0 and `busy`=0.
  - No further frames after release.
- **Parity (macro defined):** push 0x07 → parity bit 1 (three ones), frame 11 bits. Push 0x03 → parity bit 0.
- **Simultaneous push and pop:** push in the same cycle the serialiser pops, with `fifo_level`=2 → `fifo_level` stays 2 and the byte order is preserved.
